// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: load/store width codes, fault causes and
// the memory-stage control bundle.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10,
    FC_BOTH     = 2'b11
  } fault_cause_t;

  typedef struct packed {
    logic MemWr;
    logic MemRead;
    logic RegWr;
    logic MemtoReg;
  } mem_ctrl_t;

  function automatic fault_cause_t make_cause(input logic misaligned, input logic out_of_range);
    return fault_cause_t'({out_of_range, misaligned});
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational alignment and range check for a data-memory access.
// Both flags are forced low when the instruction is not a valid memory op.
module mem_access_check
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic [1:0]        addr_lsb,
  input  logic [31-ADDR_W:0] addr_hi,
  input  logic [2:0]        funct3,
  input  logic              mem_op,
  output logic              misaligned,
  output logic              out_of_range
);

  logic mis_raw;

  always_comb begin
    mis_raw = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: mis_raw = 1'b0;
      F3_H, F3_HU: mis_raw = addr_lsb[0];
      F3_W:        mis_raw = (addr_lsb != 2'b00);
      default:     mis_raw = 1'b1;  // undefined widths are reported as misaligned
    endcase
  end

  assign misaligned   = mem_op & mis_raw;
  assign out_of_range = mem_op & (|addr_hi);

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures EX results, squashes faulting loads/stores
// and keeps a sticky first-fault record until cleared.
module ex_mem_pipe_reg
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_MemWr,
  input  logic              ex_MemRead,
  input  logic              ex_RegWr,
  input  logic              ex_MemtoReg,
  input  logic              fault_clr,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_alu_result,
  output logic [31:0]       mem_write_data,
  output logic [2:0]        mem_funct3,
  output logic [4:0]        mem_rd,
  output logic              mem_MemWr,
  output logic              mem_MemRead,
  output logic              mem_RegWr,
  output logic              mem_MemtoReg,
  output logic              fault_valid,
  output logic [1:0]        fault_cause,
  output logic [31:0]       fault_addr,
  output logic              fault_is_store
);

  logic         misaligned;
  logic         out_of_range;
  logic         ex_fault;
  logic         load_en;
  mem_ctrl_t    ex_ctrl;

  logic         valid_q,   valid_d;
  logic [31:0]  alu_q,     alu_d;
  logic [31:0]  wdata_q,   wdata_d;
  logic [2:0]   funct3_q,  funct3_d;
  logic [4:0]   rd_q,      rd_d;
  mem_ctrl_t    ctrl_q,    ctrl_d;

  logic         fvalid_q,  fvalid_d;
  fault_cause_t fcause_q,  fcause_d;
  logic [31:0]  faddr_q,   faddr_d;
  logic         fstore_q,  fstore_d;

  mem_access_check #(
    .ADDR_W (ADDR_W)
  ) u_check (
    .addr_lsb     (ex_alu_result[1:0]),
    .addr_hi      (ex_alu_result[31:ADDR_W]),
    .funct3       (ex_funct3),
    .mem_op       (ex_valid & (ex_MemWr | ex_MemRead)),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  assign ex_fault = misaligned | out_of_range;
  assign load_en  = ~flush & ~stall;
  assign ex_ctrl  = '{MemWr: ex_MemWr, MemRead: ex_MemRead, RegWr: ex_RegWr, MemtoReg: ex_MemtoReg};

  always_comb begin
    valid_d  = valid_q;
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      alu_d    = ex_alu_result;
      wdata_d  = ex_store_data;
      funct3_d = ex_funct3;
      rd_d     = ex_rd;
      ctrl_d   = (ex_valid && !ex_fault) ? ex_ctrl : '0;
    end
  end

  // Clear is applied first so a fault captured on the same edge overwrites it.
  always_comb begin
    fvalid_d = fvalid_q;
    fcause_d = fcause_q;
    faddr_d  = faddr_q;
    fstore_d = fstore_q;
    if (fault_clr) begin
      fvalid_d = 1'b0;
      fcause_d = FC_NONE;
      faddr_d  = '0;
      fstore_d = 1'b0;
    end
    if (load_en && ex_fault && (!fvalid_q || fault_clr)) begin
      fvalid_d = 1'b1;
      fcause_d = make_cause(misaligned, out_of_range);
      faddr_d  = ex_alu_result;
      fstore_d = ex_MemWr;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fvalid_q <= 1'b0;
      fcause_q <= FC_NONE;
      faddr_q  <= '0;
      fstore_q <= 1'b0;
    end else begin
      fvalid_q <= fvalid_d;
      fcause_q <= fcause_d;
      faddr_q  <= faddr_d;
      fstore_q <= fstore_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_addr       = alu_q[ADDR_W-1:0];
  assign mem_alu_result = alu_q;
  assign mem_write_data = wdata_q;
  assign mem_funct3     = funct3_q;
  assign mem_rd         = rd_q;
  assign mem_MemWr      = ctrl_q.MemWr;
  assign mem_MemRead    = ctrl_q.MemRead;
  assign mem_RegWr      = ctrl_q.RegWr;
  assign mem_MemtoReg   = ctrl_q.MemtoReg;
  assign fault_valid    = fvalid_q;
  assign fault_cause    = fcause_q;
  assign fault_addr     = faddr_q;
  assign fault_is_store = fstore_q;

endmodule
